// File: rtl/fifo_flags.sv
// fifo_flags: synchronous FIFO with occupancy count, almost-full/almost-empty thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word fall-through output; otherwise reads are registered into odata.
module fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int NCBIT    = 4,
  parameter int AF_LEVEL = (1 << NCBIT) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] idata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] odata,
  output logic             ovalid,
  output logic             full,
  output logic             empty,
  output logic             afull,
  output logic             aempty,
  output logic [NCBIT:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int DEPTH = 1 << NCBIT;
  localparam logic [NCBIT:0]   C_DEPTH   = (NCBIT+1)'(DEPTH);
  localparam logic [NCBIT:0]   C_AF      = (NCBIT+1)'(AF_LEVEL);
  localparam logic [NCBIT:0]   C_AE      = (NCBIT+1)'(AE_LEVEL);
  localparam logic [NCBIT:0]   C_CNT_ONE = (NCBIT+1)'(1);
  localparam logic [NCBIT-1:0] C_PTR_ONE = NCBIT'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [NCBIT-1:0] r_wp;
  logic [NCBIT-1:0] r_rp;
  logic [NCBIT:0]   r_count;
  logic             r_ovf;
  logic             r_udf;

  logic w_full;
  logic w_empty;
  logic w_wa;
  logic w_ra;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  // A write into a full FIFO is accepted only when a pop frees a slot on the same edge.
  assign w_wa    = wr_en & (~w_full | rd_en);
  assign w_ra    = rd_en & ~w_empty;

  assign full      = w_full;
  assign empty     = w_empty;
  assign afull     = (r_count >= C_AF);
  assign aempty    = (r_count <= C_AE);
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

  always_ff @(posedge clk) begin
    if (w_wa) r_mem[r_wp] <= idata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wa) r_wp <= r_wp + C_PTR_ONE;
      if (w_ra) r_rp <= r_rp + C_PTR_ONE;
      case ({w_wa, w_ra})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
      // Set events take priority over a simultaneous clear.
      if (wr_en & ~w_wa)   r_ovf <= 1'b1;
      else if (clr_err)    r_ovf <= 1'b0;
      if (rd_en & ~w_ra)   r_udf <= 1'b1;
      else if (clr_err)    r_udf <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  assign odata  = r_mem[r_rp];
  assign ovalid = ~w_empty;
`else
  logic [WIDTH-1:0] r_odata;
  logic             r_ovalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_odata  <= '0;
      r_ovalid <= 1'b0;
    end else begin
      if (w_ra) r_odata <= r_mem[r_rp];
      r_ovalid <= w_ra;
    end
  end

  assign odata  = r_odata;
  assign ovalid = r_ovalid;
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// Testbench for fifo_flags: queue-based reference model, read scoreboard and a table of error-flag vectors.
module tb_fifo_flags;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] idata;
  logic       rd_en;
  logic [7:0] odata;
  logic       ovalid;
  logic       full;
  logic       empty;
  logic       afull;
  logic       aempty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  fifo_flags #(.WIDTH(8), .NCBIT(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .idata(idata), .rd_en(rd_en),
    .odata(odata), .ovalid(ovalid), .full(full), .empty(empty),
    .afull(afull), .aempty(aempty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       wr;
    bit       rd;
    bit       clr;
    bit [7:0] d;
    bit [4:0] e_count;
    bit       e_ovf;
    bit       e_udf;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] mq [$];
  logic [7:0] sb [$];
  bit         m_ovf;
  bit         m_udf;
  bit         e_vld;
  int         n_checks;
  int         n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] exp_flags();
    int c;
    logic [4:0] c5;
    c  = mq.size();
    c5 = 5'(c);
    return {c5, c == 16, c == 0, c >= 14, c <= 2, m_ovf, m_udf};
  endfunction

  task automatic check_outputs();
    logic [7:0] w;
    chk("flags", {count, full, empty, afull, aempty, overflow, underflow}, exp_flags());
`ifdef FIFO_FWFT_EN
    chk("ovalid", ovalid, mq.size() != 0);
    if (mq.size() != 0) chk("odata_fwft", odata, mq[0]);
`else
    chk("ovalid", ovalid, e_vld);
    if (ovalid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard: got odata %0h, expected no output", odata);
      end else begin
        w = sb.pop_front();
        chk("odata", odata, w);
      end
    end
`endif
  endtask

  task automatic step(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
    bit m_wa;
    bit m_ra;
    logic [7:0] w;
    @(negedge clk);
    wr_en = wr; idata = d; rd_en = rd; clr_err = clr;
    m_wa = wr && (mq.size() < 16 || rd);
    m_ra = rd && (mq.size() != 0);
    if (m_ra) begin
      w = mq.pop_front();
`ifndef FIFO_FWFT_EN
      sb.push_back(w);
`endif
    end
    if (m_wa) mq.push_back(d);
    if (wr && !m_wa) m_ovf = 1'b1;
    else if (clr)    m_ovf = 1'b0;
    if (rd && !m_ra) m_udf = 1'b1;
    else if (clr)    m_udf = 1'b0;
    e_vld = m_ra;
    @(posedge clk);
    #1;
    check_outputs();
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    e_vld = 1'b0;
    // {wr, rd, clr, data, count, overflow, underflow} starting from empty with errors clear
    vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 1'b0};

    rst = 1'b1; wr_en = 1'b0; idata = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_flags", {count, full, empty, afull, aempty, overflow, underflow}, 11'b00000_0_1_0_1_0_0);
    chk("reset_ovalid", ovalid, 1'b0);
`ifndef FIFO_FWFT_EN
    chk("reset_odata", odata, 8'h00);
`endif
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 12) chk("afull_13", afull, 1'b0);
      if (i == 13) chk("afull_14", afull, 1'b1);
    end
    chk("full_16", {full, count}, {1'b1, 5'd16});
    step(1'b1, 8'h10, 1'b0, 1'b0);
    chk("ovf_17", {overflow, count}, {1'b1, 5'd16});
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("full_rw_count", count, 5'd16);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained", {empty, count}, {1'b1, 5'd0});
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", overflow, 1'b0);

    for (int i = 0; i < 5; i++) begin
      step(vecs[i].wr, vecs[i].d, vecs[i].rd, vecs[i].clr);
      chk("vec_count", count, vecs[i].e_count);
      chk("vec_ovf", overflow, vecs[i].e_ovf);
      chk("vec_udf", underflow, vecs[i].e_udf);
    end

    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_count", count, 5'd7);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_flags", {count, full, empty, afull, aempty, overflow, underflow}, 11'b00000_0_1_0_1_0_0);
    chk("async_rst_ovalid", ovalid, 1'b0);
`ifndef FIFO_FWFT_EN
    chk("async_rst_odata", odata, 8'h00);
`endif
    mq.delete();
    sb.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_empty", empty, 1'b1);

`ifndef FIFO_FWFT_EN
    chk("sb_leftover", sb.size(), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
